// File: rtl/wash_program_sequencer.sv
// Wash program controller: sequences fill, wash, drain, rinse passes and spin
// with an internal prescaler/phase counter, door-open pause and abort handling.
module wash_program_sequencer #(
  parameter int TICK_DIV  = 1,
  parameter int CNT_W     = 8,
  parameter int FILL_BASE = 2,
  parameter int WASH_BASE = 4,
  parameter int RINSE_T   = 3,
  parameter int DRAIN_T   = 2,
  parameter int SPIN_T    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       door,
  input  logic       abort,
  input  logic [1:0] load,
  input  logic [1:0] rinses,
  output logic       agitator,
  output logic       motor,
  output logic       pump,
  output logic       speed,
  output logic       water,
  output logic [2:0] phase,
  output logic       paused,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state_q, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       load_q, load_d;
  logic [1:0]       rinse_left_q, rinse_left_d;
  logic             rinse_flag_q, rinse_flag_d;
  logic             abort_flag_q, abort_flag_d;
  logic             paused_d;
  logic             done_d;
  logic [4:0]       act_q, act_d;
  logic             tick, expire, enter, run;

  function automatic logic [CNT_W-1:0] dur(input state_t s, input logic [1:0] ld);
    logic [CNT_W-1:0] units;
    units = CNT_W'(ld) + CNT_W'(1);
    case (s)
      FILL:    dur = CNT_W'(FILL_BASE) * units;
      WASH:    dur = CNT_W'(WASH_BASE) * units;
      RINSE:   dur = CNT_W'(RINSE_T);
      DRAIN:   dur = CNT_W'(DRAIN_T);
      SPIN:    dur = CNT_W'(SPIN_T);
      default: dur = '0;
    endcase
  endfunction

  function automatic logic pausable(input state_t s);
    pausable = (s == FILL) || (s == WASH) || (s == RINSE) || (s == SPIN);
  endfunction

  // Next-state, counter and latch logic; a phase ends on the tick that takes the count to zero.
  always_comb begin
    nxt          = state_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    load_d       = load_q;
    rinse_left_d = rinse_left_q;
    rinse_flag_d = rinse_flag_q;
    abort_flag_d = abort_flag_q;
    enter        = 1'b0;
    tick         = (presc_q == PW'(TICK_DIV - 1));
    expire       = tick && (cnt_q <= CNT_W'(1));
    run          = (state_q == DRAIN) || (pausable(state_q) && !paused);

    case (state_q)
      IDLE: begin
        abort_flag_d = 1'b0;
        rinse_flag_d = 1'b0;
        if (start && door && !abort) begin
          load_d       = load;
          rinse_left_d = rinses;
          nxt          = FILL;
          enter        = 1'b1;
        end
      end
      FILL, WASH, RINSE, SPIN: begin
        if (abort) begin
          nxt          = DRAIN;
          enter        = 1'b1;
          abort_flag_d = 1'b1;
        end else if (!paused && expire) begin
          enter = 1'b1;
          case (state_q)
            FILL:    nxt = rinse_flag_q ? RINSE : WASH;
            SPIN:    nxt = DONE;
            default: nxt = DRAIN;
          endcase
        end
      end
      DRAIN: begin
        if (abort) abort_flag_d = 1'b1;
        if (expire) begin
          enter = 1'b1;
          if (abort_flag_q || abort) begin
            nxt = IDLE;
          end else if (rinse_left_q != 2'd0) begin
            rinse_left_d = rinse_left_q - 2'd1;
            rinse_flag_d = 1'b1;
            nxt          = FILL;
          end else begin
            nxt = SPIN;
          end
        end
      end
      DONE: begin
        if (!start) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    if (enter) begin
      cnt_d   = dur(nxt, load_d);
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) cnt_d = cnt_q - CNT_W'(1);
    end

    paused_d = pausable(nxt) && !door;
    done_d   = (nxt == DONE);
  end

  // Actuator pattern for the phase being entered: {agitator, motor, pump, speed, water}.
  always_comb begin
    act_d = 5'b00000;
    if (!paused_d) begin
      case (nxt)
        FILL:        act_d = 5'b00001;
        WASH, RINSE: act_d = 5'b11000;
        DRAIN:       act_d = 5'b00100;
        SPIN:        act_d = 5'b01110;
        default:     act_d = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      presc_q      <= '0;
      load_q       <= '0;
      rinse_left_q <= '0;
      rinse_flag_q <= 1'b0;
      abort_flag_q <= 1'b0;
      paused       <= 1'b0;
      done         <= 1'b0;
      act_q        <= '0;
    end else begin
      state_q      <= nxt;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      load_q       <= load_d;
      rinse_left_q <= rinse_left_d;
      rinse_flag_q <= rinse_flag_d;
      abort_flag_q <= abort_flag_d;
      paused       <= paused_d;
      done         <= done_d;
      act_q        <= act_d;
    end
  end

  assign {agitator, motor, pump, speed, water} = act_q;
  assign phase = state_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed self-checking bench for wash_program_sequencer: full programs,
// rinse passes, door pause, abort, start gating and asynchronous reset.
module tb_wash_program_sequencer;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_FILL  = 3'd1;
  localparam logic [2:0] P_WASH  = 3'd2;
  localparam logic [2:0] P_DRAIN = 3'd3;
  localparam logic [2:0] P_RINSE = 3'd4;
  localparam logic [2:0] P_SPIN  = 3'd5;
  localparam logic [2:0] P_DONE  = 3'd6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, door, abort;
  logic [1:0] load, rinses;
  logic       agitator, motor, pump, speed, water;
  logic [2:0] phase;
  logic       paused, done;

  int checks = 0;
  int errors = 0;

  wash_program_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .door(door), .abort(abort),
    .load(load), .rinses(rinses), .agitator(agitator), .motor(motor), .pump(pump),
    .speed(speed), .water(water), .phase(phase), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {agitator, motor, pump, speed, water} for an unpaused phase.
  function automatic logic [4:0] expAct(input logic [2:0] ph);
    case (ph)
      P_FILL:          expAct = 5'b00001;
      P_WASH, P_RINSE: expAct = 5'b11000;
      P_DRAIN:         expAct = 5'b00100;
      P_SPIN:          expAct = 5'b01110;
      default:         expAct = 5'b00000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic a,
                               input logic [1:0] l, input logic [1:0] r);
    start  = s;
    door   = d;
    abort  = a;
    load   = l;
    rinses = r;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] ph,
                             input logic pz, input logic dn);
    logic [9:0] obs, exp;
    obs = {phase, paused, done, agitator, motor, pump, speed, water};
    exp = {ph, pz, dn, pz ? 5'b00000 : expAct(ph)};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%b expected=%b (phase,paused,done,ag,mo,pu,sp,wa)",
               tag, obs, exp);
      end
  endtask

  // Checks n consecutive unpaused clocks of the given phase, advancing one edge each.
  task automatic expectPhase(input string tag, input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_%0d", tag, i), ph, 1'b0, ph == P_DONE);
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    #17;
    checkOutput("reset", P_IDLE, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    checkOutput("idle_after_reset", P_IDLE, 1'b0, 1'b0);

    $display("[TB] program 1: load=0 rinses=0");
    applyStimulus(1, 1, 0, 2'd0, 2'd0);
    step();
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    expectPhase("p1_fill", P_FILL, 2);
    expectPhase("p1_wash", P_WASH, 4);
    expectPhase("p1_drain", P_DRAIN, 2);
    expectPhase("p1_spin", P_SPIN, 5);
    checkOutput("p1_done", P_DONE, 1'b0, 1'b1);
    step();
    checkOutput("p1_idle", P_IDLE, 1'b0, 1'b0);

    $display("[TB] program 2: load=3 rinses=2, start held, inputs changed after accept");
    applyStimulus(1, 1, 0, 2'd3, 2'd2);
    step();
    applyStimulus(1, 1, 0, 2'd0, 2'd0);
    expectPhase("p2_fill", P_FILL, 8);
    expectPhase("p2_wash", P_WASH, 16);
    expectPhase("p2_drain", P_DRAIN, 2);
    for (int p = 0; p < 2; p++) begin
      expectPhase($sformatf("p2_r%0d_fill", p), P_FILL, 8);
      expectPhase($sformatf("p2_r%0d_rinse", p), P_RINSE, 3);
      expectPhase($sformatf("p2_r%0d_drain", p), P_DRAIN, 2);
    end
    expectPhase("p2_spin", P_SPIN, 5);
    expectPhase("p2_done_held", P_DONE, 3);
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    checkOutput("p2_done_release", P_DONE, 1'b0, 1'b1);
    step();
    checkOutput("p2_idle", P_IDLE, 1'b0, 1'b0);

    $display("[TB] program 3: door pause in WASH, door open in DRAIN");
    applyStimulus(1, 1, 0, 2'd0, 2'd0);
    step();
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    expectPhase("p3_fill", P_FILL, 2);
    expectPhase("p3_wash", P_WASH, 2);
    checkOutput("p3_wash_pre", P_WASH, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 2'd0, 2'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("p3_wash_paused_%0d", i), P_WASH, 1'b1, 1'b0);
      if (i == 3) applyStimulus(0, 1, 0, 2'd0, 2'd0);
      step();
    end
    checkOutput("p3_wash_resume", P_WASH, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 2'd0, 2'd0);
    step();
    expectPhase("p3_drain_door_open", P_DRAIN, 2);
    checkOutput("p3_spin_starts_paused", P_SPIN, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    step();
    expectPhase("p3_spin", P_SPIN, 5);
    checkOutput("p3_done", P_DONE, 1'b0, 1'b1);
    step();
    checkOutput("p3_idle", P_IDLE, 1'b0, 1'b0);

    $display("[TB] program 4: abort in first rinse pass");
    applyStimulus(1, 1, 0, 2'd0, 2'd2);
    step();
    applyStimulus(0, 1, 0, 2'd0, 2'd2);
    expectPhase("p4_fill", P_FILL, 2);
    expectPhase("p4_wash", P_WASH, 4);
    expectPhase("p4_drain", P_DRAIN, 2);
    expectPhase("p4_r0_fill", P_FILL, 2);
    checkOutput("p4_rinse", P_RINSE, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 2'd0, 2'd2);
    step();
    checkOutput("p4_abort_drain_0", P_DRAIN, 1'b0, 1'b0);
    step();
    checkOutput("p4_abort_drain_1", P_DRAIN, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 2'd2);
    step();
    checkOutput("p4_abort_idle_0", P_IDLE, 1'b0, 1'b0);
    step();
    checkOutput("p4_abort_idle_1", P_IDLE, 1'b0, 1'b0);

    $display("[TB] start with door open");
    applyStimulus(1, 0, 0, 2'd1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("door_open_start_%0d", i), P_IDLE, 1'b0, 1'b0);
    end

    $display("[TB] program 6: async reset mid-SPIN");
    applyStimulus(1, 1, 0, 2'd0, 2'd0);
    step();
    applyStimulus(0, 1, 0, 2'd0, 2'd0);
    expectPhase("p6_fill", P_FILL, 2);
    expectPhase("p6_wash", P_WASH, 4);
    expectPhase("p6_drain", P_DRAIN, 2);
    expectPhase("p6_spin", P_SPIN, 2);
    checkOutput("p6_spin_before_reset", P_SPIN, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("p6_async_reset", P_IDLE, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    step();
    checkOutput("p6_idle_0", P_IDLE, 1'b0, 1'b0);
    step();
    checkOutput("p6_idle_1", P_IDLE, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 2'd0, 2'd0);
    step();
    checkOutput("p6_restart_fill", P_FILL, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
